asi_arb: RTL and testbench



---
 rtl/asi_arb.sv | 169 ++++++++++++++++
 tb/tb_asi_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asi_arb.sv
// asi_arb: burst-locked arbiter sharing one single-port RAM between NREQ
// read/write engines. Fixed-priority or round-robin winner selection, an
// optional beat cap that forces a handover when someone else is waiting,
// and a read-return pipeline matched to the RAM read latency.
//
//   state | meaning
//   IDLE  | no grant held; any req is granted on the next cycle
//   BUSY  | exactly one grant bit set; holder owns the RAM port until its
//         | tenure ends (last beat, or beat cap reached with others waiting)
module asi_arb #(
  parameter int NREQ       = 4,
  parameter int AXI_AW     = 32,
  parameter int AXI_DW     = 128,
  parameter int AXI_WSTRBW = AXI_DW / 8,
  parameter int ARB_MODE   = 0,
  parameter int MAX_BEATS  = 0,
  parameter int SLV_WS     = 1
) (
  input  logic                         usr_clk,
  input  logic                         usr_reset,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              we,
  input  logic [NREQ-1:0]              re,
  input  logic [NREQ-1:0]              last,
  input  logic [NREQ*AXI_AW-1:0]       addr,
  input  logic [NREQ*AXI_DW-1:0]       wdata,
  input  logic [NREQ*AXI_WSTRBW-1:0]   wstrb,
  output logic [NREQ-1:0]              grant,
  output logic [NREQ-1:0]              rd_vld,
  output logic [AXI_DW-1:0]            rd_data,
  output logic                         RAM_CEN,
  output logic [AXI_WSTRBW-1:0]        RAM_WEN,
  output logic [AXI_AW-1:0]            RAM_A,
  output logic [AXI_DW-1:0]            RAM_D,
  input  logic [AXI_DW-1:0]            RAM_Q
);

  localparam int GW  = $clog2(NREQ);
  localparam int BCW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [NREQ-1:0]   grant_nxt, others, cand;
  logic [GW-1:0]     gidx, win, rr_ptr, rr_nxt;
  logic [GW:0]       rr_j;
  logic [BCW-1:0]    beat_cnt;
  logic              access, wr_acc, rd_acc, cap_hit;
  logic              end_norm, end_forced, tenure_end, issue;
  logic [SLV_WS-1:0] pipe_vld;
  logic [GW-1:0]     pipe_idx [SLV_WS];

  // Encode the one-hot grant into the holder index.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) gidx = GW'(i);
  end

  // A write wins over a simultaneous read; the read is simply dropped.
  assign access     = |(grant & (we | re));
  assign wr_acc     = |(grant & we);
  assign rd_acc     = access & ~wr_acc;
  assign others     = req & ~grant;
  assign cap_hit    = (MAX_BEATS > 0) &&
                      (({1'b0, beat_cnt} + 1'b1) >= (BCW+1)'(MAX_BEATS));
  assign end_norm   = access & last[gidx];
  assign end_forced = access & cap_hit & (|others);
  assign tenure_end = end_norm | end_forced;
  // A forced handover must actually hand over, so the holder is excluded.
  assign cand       = end_forced ? others : req;

  // Winner: lowest index (fixed) or first index after the last holder (RR).
  always_comb begin
    win  = '0;
    rr_j = '0;
    if (ARB_MODE == 0) begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (cand[i]) win = GW'(i);
    end else begin
      for (int i = NREQ; i >= 1; i--) begin
        rr_j = {1'b0, rr_ptr} + (GW+1)'(i);
        if (rr_j >= (GW+1)'(NREQ)) rr_j = rr_j - (GW+1)'(NREQ);
        if (cand[rr_j[GW-1:0]]) win = rr_j[GW-1:0];
      end
    end
  end

  // Next state, next grant and round-robin pointer.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    issue     = 1'b0;
    if (state == IDLE || tenure_end) begin
      if (|cand) begin
        state_nxt      = BUSY;
        grant_nxt      = '0;
        grant_nxt[win] = 1'b1;
        rr_nxt         = win;
        issue          = 1'b1;
      end else begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    end
  end

  // State, grant and pointer registers.
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= GW'(NREQ - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Beat counter: cleared per grant, saturates at the cap.
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset)
      beat_cnt <= '0;
    else if (issue)
      beat_cnt <= '0;
    else if (access && (MAX_BEATS > 0) &&
             ({1'b0, beat_cnt} < (BCW+1)'(MAX_BEATS)))
      beat_cnt <= beat_cnt + 1'b1;
  end

  // Read-return pipeline; entries survive a handover.
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < SLV_WS; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      pipe_idx[0] <= gidx;
      for (int i = 1; i < SLV_WS; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // One-hot read valid from the pipeline tail; data is the RAM output.
  always_comb begin
    rd_vld = '0;
    if (pipe_vld[SLV_WS-1]) rd_vld[pipe_idx[SLV_WS-1]] = 1'b1;
  end

  assign rd_data = RAM_Q;

  // RAM port mux driven from the registered grant.
  always_comb begin
    RAM_A   = '0;
    RAM_D   = '0;
    RAM_WEN = '1;
    if (|grant) begin
      RAM_A   = addr[gidx*AXI_AW +: AXI_AW];
      RAM_D   = wdata[gidx*AXI_DW +: AXI_DW];
      RAM_WEN = ~(wstrb[gidx*AXI_WSTRBW +: AXI_WSTRBW] & {AXI_WSTRBW{we[gidx]}});
    end
    RAM_CEN = ~access;
  end

endmodule

// File: tb/tb_asi_arb.sv
// Bench for asi_arb: a fixed-priority instance (no cap) and a round-robin
// instance (cap of 4 beats) share stimulus. Read returns of the round-robin
// instance are checked against a queue of expected (cycle, valid, data).
module tb_asi_arb;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            usr_reset;
  logic [N-1:0]    req, we, re, last;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*SW-1:0] wstrb;
  logic [DW-1:0]   ram_q;
  int unsigned     cyc = 0;

  logic [N-1:0]  grant_fp, rd_vld_fp, grant_rr, rd_vld_rr;
  logic [DW-1:0] rd_data_fp, rd_data_rr, ram_d_fp, ram_d_rr;
  logic          cen_fp, cen_rr;
  logic [SW-1:0] wen_fp, wen_rr;
  logic [AW-1:0] ram_a_fp, ram_a_rr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int unsigned cyc;
    logic [N-1:0] vld;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ram_q = 32'hD000_0000 + cyc;

  asi_arb #(.NREQ(N), .AXI_AW(AW), .AXI_DW(DW), .AXI_WSTRBW(SW),
            .ARB_MODE(0), .MAX_BEATS(0), .SLV_WS(2)) dut_fp (
    .usr_clk(clk), .usr_reset(usr_reset), .req(req), .we(we), .re(re),
    .last(last), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .grant(grant_fp), .rd_vld(rd_vld_fp), .rd_data(rd_data_fp),
    .RAM_CEN(cen_fp), .RAM_WEN(wen_fp), .RAM_A(ram_a_fp), .RAM_D(ram_d_fp),
    .RAM_Q(ram_q));

  asi_arb #(.NREQ(N), .AXI_AW(AW), .AXI_DW(DW), .AXI_WSTRBW(SW),
            .ARB_MODE(1), .MAX_BEATS(4), .SLV_WS(2)) dut_rr (
    .usr_clk(clk), .usr_reset(usr_reset), .req(req), .we(we), .re(re),
    .last(last), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .grant(grant_rr), .rd_vld(rd_vld_rr), .rd_data(rd_data_rr),
    .RAM_CEN(cen_rr), .RAM_WEN(wen_rr), .RAM_A(ram_a_rr), .RAM_D(ram_d_rr),
    .RAM_Q(ram_q));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [N-1:0] v);
    sb_t e;
    e.cyc  = cyc + 2;
    e.vld  = v;
    e.data = 32'hD000_0000 + cyc + 2;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    usr_reset = 1'b1;
    req = '0; we = '0; re = '0; last = '0;
    addr = '0; wdata = '0; wstrb = '0;
    sb.delete();
    @(negedge clk);
    check("rst_grant_fp", 64'(grant_fp), 64'(0));
    check("rst_grant_rr", 64'(grant_rr), 64'(0));
    check("rst_cen", 64'(cen_fp), 64'(1));
    check("rst_wen", 64'(wen_rr), 64'(4'hF));
    check("rst_addr", 64'(ram_a_fp), 64'(0));
    check("rst_rdvld", 64'(rd_vld_rr), 64'(0));
    @(posedge clk);
    #1 usr_reset = 1'b0;
  endtask

  // Read-return scoreboard for the round-robin instance.
  always @(negedge clk) begin
    if (!usr_reset) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        sb_t e;
        e = sb.pop_front();
        check("rd_vld", 64'(rd_vld_rr), 64'(e.vld));
        check("rd_data", 64'(rd_data_rr), 64'(e.data));
      end else if (rd_vld_rr != '0) begin
        check("rd_vld_spurious", 64'(rd_vld_rr), 64'(0));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] ws, ew;
    logic [N-1:0]  g_exp [6];
    int            i_exp [6];

    // Single write burst on requester 2.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    check("t1_idle", 64'(grant_fp), 64'(0));
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      ws = SW'(b * 3 + 3);
      we = 4'b0100;
      addr[2*AW +: AW]  = AW'(16'h100 + 16 * b);
      wdata[2*DW +: DW] = 32'hCAFE_0000 + b;
      wstrb[2*SW +: SW] = ws;
      last = (b == 3) ? 4'b0100 : 4'b0000;
      if (b == 3) req = 4'b0000;
      ew = ~ws;
      @(negedge clk);
      check("t1_grant", 64'(grant_fp), 64'(4'b0100));
      check("t1_cen", 64'(cen_fp), 64'(0));
      check("t1_wen", 64'(wen_fp), 64'(ew));
      check("t1_addr", 64'(ram_a_fp), 64'(16'h100 + 16 * b));
      check("t1_data", 64'(ram_d_fp), 64'(32'hCAFE_0000 + b));
    end
    next_cycle();
    we = '0; last = '0;
    @(negedge clk);
    check("t1_end_grant", 64'(grant_fp), 64'(0));
    check("t1_end_cen", 64'(cen_fp), 64'(1));

    // Fixed priority, req 1 and 3 together, 2 beats each, no gap.
    do_reset();
    req = 4'b1010;
    wstrb = '1;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      we   = (c <= 4) ? 4'b1010 : 4'b0000;
      addr[1*AW +: AW] = AW'(16'h200 + 16 * (c - 1));
      addr[3*AW +: AW] = (c <= 2) ? AW'(16'h3F0) : AW'(16'h300 + 16 * (c - 3));
      last = (c == 2) ? 4'b0010 : (c == 4) ? 4'b1000 : 4'b0000;
      if (c == 2) req = 4'b1000;
      if (c == 4) req = 4'b0000;
      @(negedge clk);
      case (c)
        1, 2: begin
          check("t2_grant1", 64'(grant_fp), 64'(4'b0010));
          check("t2_addr1", 64'(ram_a_fp), 64'(16'h200 + 16 * (c - 1)));
        end
        3, 4: begin
          check("t2_grant3", 64'(grant_fp), 64'(4'b1000));
          check("t2_addr3", 64'(ram_a_fp), 64'(16'h300 + 16 * (c - 3)));
        end
        default: check("t2_idle", 64'(grant_fp), 64'(0));
      endcase
    end

    // Round robin, all requesting, 1-beat bursts.
    do_reset();
    g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    i_exp = '{0, 1, 2, 3, 0, 1};
    req = '1; we = '1; last = '1; wstrb = '1;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(16'hA000 + i);
    @(negedge clk);
    check("t3_idle", 64'(grant_rr), 64'(0));
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      check("t3_rr_grant", 64'(grant_rr), 64'(g_exp[i]));
      check("t3_rr_addr", 64'(ram_a_rr), 64'(16'hA000 + i_exp[i]));
      check("t3_fp_grant", 64'(grant_fp), 64'(4'b0001));
    end

    // Beat cap with requester 1 waiting.
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      re = 4'b0001;
      we = 4'b0010;
      last = 4'b0010;
      wstrb[1*SW +: SW] = '1;
      addr[0 +: AW] = AW'(16'h1000 + 16 * b);
      addr[1*AW +: AW] = AW'(16'h2000);
      push_rd(4'b0001);
      @(negedge clk);
      check("t4_cap_grant0", 64'(grant_rr), 64'(4'b0001));
      check("t4_cap_addr", 64'(ram_a_rr), 64'(16'h1000 + 16 * b));
    end
    next_cycle();
    re = '0;
    req = 4'b0001;
    @(negedge clk);
    check("t4_cap_grant1", 64'(grant_rr), 64'(4'b0010));
    check("t4_cap_wen", 64'(wen_rr), 64'(0));
    check("t4_cap_addr1", 64'(ram_a_rr), 64'(16'h2000));
    next_cycle();
    we = '0; last = '0;
    @(negedge clk);
    check("t4_regrant0", 64'(grant_rr), 64'(4'b0001));
    repeat (3) next_cycle();

    // Same burst without a waiter: 16 uninterrupted beats.
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      next_cycle();
      re = 4'b0001;
      addr[0 +: AW] = AW'(16'h1000 + 16 * b);
      last = (b == 15) ? 4'b0001 : 4'b0000;
      if (b == 15) req = '0;
      push_rd(4'b0001);
      @(negedge clk);
      check("t4_long_grant", 64'(grant_rr), 64'(4'b0001));
    end
    next_cycle();
    re = '0; last = '0;
    @(negedge clk);
    check("t4_long_end", 64'(grant_rr), 64'(0));
    repeat (3) next_cycle();

    // Read return across a handover; write wins over read on requester 1.
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    next_cycle();
    re = 4'b1000;
    addr[3*AW +: AW] = AW'(16'h40);
    last = 4'b1000;
    req = 4'b0010;
    push_rd(4'b1000);
    @(negedge clk);
    check("t5_grant3", 64'(grant_rr), 64'(4'b1000));
    check("t5_addr", 64'(ram_a_rr), 64'(16'h40));
    check("t5_cen", 64'(cen_rr), 64'(0));
    check("t5_wen_read", 64'(wen_rr), 64'(4'hF));
    next_cycle();
    re = 4'b0010; we = 4'b0010; last = 4'b0010; req = '0;
    wstrb[1*SW +: SW] = 4'h6;
    addr[1*AW +: AW] = AW'(16'h50);
    @(negedge clk);
    check("t5_grant1", 64'(grant_rr), 64'(4'b0010));
    check("t5_wen_write", 64'(wen_rr), 64'(4'h9));
    check("t5_addr1", 64'(ram_a_rr), 64'(16'h50));
    next_cycle();
    re = '0; we = '0; last = '0;
    @(negedge clk);
    check("t5_idle", 64'(grant_rr), 64'(0));
    repeat (3) next_cycle();

    // Reset in the middle of a burst with a read in flight.
    do_reset();
    req = 4'b0001;
    wstrb = '1;
    next_cycle();
    we = 4'b0001;
    addr[0 +: AW] = AW'(16'h500);
    @(negedge clk);
    check("t6_grant", 64'(grant_fp), 64'(4'b0001));
    next_cycle();
    we = '0; re = 4'b0001;
    addr[0 +: AW] = AW'(16'h510);
    next_cycle();
    re = '0; we = 4'b0001;
    addr[0 +: AW] = AW'(16'h520);
    #2 usr_reset = 1'b1;
    #1;
    check("t6_rst_grant_fp", 64'(grant_fp), 64'(0));
    check("t6_rst_grant_rr", 64'(grant_rr), 64'(0));
    check("t6_rst_cen", 64'(cen_fp), 64'(1));
    check("t6_rst_rdvld", 64'(rd_vld_rr), 64'(0));
    @(posedge clk);
    #1 usr_reset = 1'b0;
    @(negedge clk);
    check("t6_rel_grant", 64'(grant_fp), 64'(0));
    next_cycle();
    @(negedge clk);
    check("t6_regrant", 64'(grant_fp), 64'(4'b0001));
    check("t6_regrant_cen", 64'(cen_fp), 64'(0));
    next_cycle();
    req = '0; we = '0;
    repeat (3) next_cycle();

    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
